// File: rtl/divider_if.sv
// Operand/result bundle between the microcode operand path and the divider.
interface divider_if;
    logic        start;
    logic        is_8_bit;
    logic        is_signed;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        busy;
    logic        complete;
    logic        raise_div_zero;

    modport master (
        output start, is_8_bit, is_signed, dividend, divisor,
        input  quotient, remainder, busy, complete, raise_div_zero
    );

    modport slave (
        input  start, is_8_bit, is_signed, dividend, divisor,
        output quotient, remainder, busy, complete, raise_div_zero
    );
endinterface

// File: rtl/divider.sv
// Iterative restoring divider for DIV/IDIV: one quotient bit per cycle on
// operand magnitudes, sign fix-up at the end, divide-error flag for INT 0.
module divider (
    input  logic     clk,
    input  logic     reset_n,
    divider_if.slave bus
);
    typedef enum logic [2:0] {IDLE, INIT, DIVIDE, FIXUP, DONE} state_t;

    state_t state, state_nx;

    // Captured request
    logic [31:0] dvd_l;
    logic [15:0] dvs_l;
    logic        is8_l;
    logic        sgn_l;

    // Iteration state
    logic [15:0] dvs_m;
    logic [15:0] prem;
    logic [15:0] qreg;
    logic [4:0]  cnt;
    logic        q_neg;
    logic        r_neg;
    logic        err;

    // Result registers, held until the next result lands
    logic [15:0] q_out;
    logic [15:0] r_out;

    logic busy;
    logic complete;
    logic accept;

    function automatic logic [31:0] negate32(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    // Apply a sign to an N-bit magnitude; upper byte forced to zero in 8-bit mode.
    function automatic logic [15:0] apply_sign(input logic [15:0] mag, input logic neg,
                                               input logic is8);
        logic [15:0] v;
        v = neg ? (~mag + 16'd1) : mag;
        if (is8) v[15:8] = 8'h00;
        return v;
    endfunction

    // IDIV quotient must lie in -(2^(N-1)-1)..+(2^(N-1)-1); a magnitude of
    // exactly 2^(N-1) raises even when negative, as the 8086 does.
    function automatic logic quot_overflow(input logic [15:0] mag, input logic sgn,
                                           input logic is8);
        return sgn && (mag > (is8 ? 16'h007F : 16'h7FFF));
    endfunction

    // INIT: operand magnitudes, sign bookkeeping and the early error check
    logic        dvd_neg;
    logic        dvs_neg;
    logic [31:0] dvd_raw;
    logic [31:0] dvd_abs;
    logic [31:0] dvd_mag;
    logic [15:0] dvs_raw;
    logic [15:0] dvs_abs;
    logic [15:0] dvs_mag;
    logic [15:0] dvd_hi;
    logic [15:0] dvd_lo;
    logic        init_err;

    // Magnitudes and the quotient-does-not-fit test, evaluated from the captured operands
    always_comb begin
        dvd_neg  = sgn_l & (is8_l ? dvd_l[15] : dvd_l[31]);
        dvs_neg  = sgn_l & (is8_l ? dvs_l[7] : dvs_l[15]);
        dvd_raw  = is8_l ? {16'h0000, dvd_l[15:0]} : dvd_l;
        dvs_raw  = is8_l ? {8'h00, dvs_l[7:0]} : dvs_l;
        dvd_abs  = dvd_neg ? negate32(dvd_raw) : dvd_raw;
        dvs_abs  = dvs_neg ? (~dvs_raw + 16'd1) : dvs_raw;
        dvd_mag  = is8_l ? {16'h0000, dvd_abs[15:0]} : dvd_abs;
        dvs_mag  = is8_l ? {8'h00, dvs_abs[7:0]} : dvs_abs;
        dvd_hi   = is8_l ? {8'h00, dvd_mag[15:8]} : dvd_mag[31:16];
        dvd_lo   = is8_l ? {8'h00, dvd_mag[7:0]} : dvd_mag[15:0];
        init_err = (dvs_mag == 16'h0000) || (dvd_hi >= dvs_mag);
    end

    // DIVIDE: shift {prem, qreg} left and trial-subtract the divisor magnitude.
    // The shifted remainder needs N+1 bits; comparing at that width is the
    // borrow test of the trial subtract, and a kept difference always fits N bits.
    logic        shift_in;
    logic [16:0] shifted;
    logic [15:0] diff;
    logic        q_bit;

    // One restoring-division step
    always_comb begin
        shift_in = is8_l ? qreg[7] : qreg[15];
        shifted  = {prem, shift_in};
        q_bit    = (shifted >= {1'b0, dvs_m});
        diff     = shifted[15:0] - dvs_m;
    end

    // FIXUP: signed results and the IDIV range check
    logic [15:0] q_mag;
    logic [15:0] q_fin;
    logic [15:0] r_fin;
    logic        ovf;

    // Final signs and overflow from the unsigned quotient/remainder
    always_comb begin
        q_mag = is8_l ? {8'h00, qreg[7:0]} : qreg;
        q_fin = apply_sign(q_mag, q_neg, is8_l);
        r_fin = apply_sign(prem, r_neg, is8_l);
        ovf   = quot_overflow(q_mag, sgn_l, is8_l);
    end

    // A request is taken in IDLE and in DONE, allowing back-to-back divides
    assign accept = bus.start && ((state == IDLE) || (state == DONE));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state and status outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nx = INIT;
            end
            INIT: begin
                busy     = 1'b1;
                state_nx = init_err ? DONE : DIVIDE;
            end
            DIVIDE: begin
                busy = 1'b1;
                if (cnt == 5'd1) state_nx = FIXUP;
            end
            FIXUP: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                complete = 1'b1;
                state_nx = accept ? INIT : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dvd_l <= '0;
            dvs_l <= '0;
            is8_l <= 1'b0;
            sgn_l <= 1'b0;
            dvs_m <= '0;
            prem  <= '0;
            qreg  <= '0;
            cnt   <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            err   <= 1'b0;
            q_out <= '0;
            r_out <= '0;
        end else begin
            if (accept) begin
                dvd_l <= bus.dividend;
                dvs_l <= bus.divisor;
                is8_l <= bus.is_8_bit;
                sgn_l <= bus.is_signed;
            end
            case (state)
                INIT: begin
                    q_neg <= dvd_neg ^ dvs_neg;
                    r_neg <= dvd_neg;
                    dvs_m <= dvs_mag;
                    prem  <= dvd_hi;
                    qreg  <= dvd_lo;
                    cnt   <= is8_l ? 5'd8 : 5'd16;
                    err   <= init_err;
                    if (init_err) begin
                        q_out <= '0;
                        r_out <= '0;
                    end
                end
                DIVIDE: begin
                    prem <= q_bit ? diff : shifted[15:0];
                    qreg <= {qreg[14:0], q_bit};
                    cnt  <= cnt - 5'd1;
                end
                FIXUP: begin
                    err <= ovf;
                    if (ovf) begin
                        q_out <= '0;
                        r_out <= '0;
                    end else begin
                        q_out <= q_fin;
                        r_out <= r_fin;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.quotient       = q_out;
    assign bus.remainder      = r_out;
    assign bus.busy           = busy;
    assign bus.complete       = complete;
    assign bus.raise_div_zero = complete & err;
endmodule

// File: tb/tb_divider.sv
// Bench for the DIV/IDIV divider: directed cases plus random operands
// against an integer-arithmetic reference model.
module tb_divider;
    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    divider_if dif();

    divider dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division with truncation toward zero.
    task automatic model(input logic [31:0] dvd, input logic [15:0] dvs, input bit is8,
                         input bit sgn, output logic [15:0] q, output logic [15:0] r,
                         output bit err, output int lat);
        longint a, b, qq, rr, qmag;
        int n;
        logic signed [15:0] s16a;
        logic signed [31:0] s32a;
        logic signed [7:0]  s8b;
        logic signed [15:0] s16b;
        n = is8 ? 8 : 16;
        if (is8) begin
            if (sgn) begin s16a = dvd[15:0]; s8b = dvs[7:0]; a = s16a; b = s8b; end
            else begin a = longint'(dvd[15:0]); b = longint'(dvs[7:0]); end
        end else begin
            if (sgn) begin s32a = dvd; s16b = dvs; a = s32a; b = s16b; end
            else begin a = longint'(dvd); b = longint'(dvs); end
        end
        q = '0; r = '0; err = 0; lat = 2;
        if (b == 0) begin
            err = 1;
        end else begin
            qq = a / b;
            rr = a - qq * b;
            qmag = (qq < 0) ? -qq : qq;
            if (qmag >= (longint'(1) << n)) begin
                err = 1;
            end else begin
                lat = n + 3;
                if (sgn && (qmag > (longint'(1) << (n - 1)) - 1)) begin
                    err = 1;
                end else begin
                    q = qq[15:0];
                    r = rr[15:0];
                    if (is8) begin q[15:8] = 8'h00; r[15:8] = 8'h00; end
                end
            end
        end
    endtask

    // Issue one divide (called on a falling edge) and follow it to completion.
    // poke>0 re-pulses start with junk operands at that cycle.
    task automatic run_div(input logic [31:0] dvd, input logic [15:0] dvs, input bit is8,
                           input bit sgn, input int poke, input string tag);
        logic [15:0] eq, er;
        bit ee;
        int lat;
        model(dvd, dvs, is8, sgn, eq, er, ee, lat);
        dif.start = 1'b1; dif.dividend = dvd; dif.divisor = dvs;
        dif.is_8_bit = is8; dif.is_signed = sgn;
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            dif.start = 1'b0;
            if (c == poke) begin
                dif.start = 1'b1; dif.dividend = $urandom; dif.divisor = 16'($urandom);
                dif.is_8_bit = ~is8; dif.is_signed = ~sgn;
            end
            if (c < lat) begin
                checks++;
                if ({dif.busy, dif.complete} !== 2'b10) begin
                    errors++;
                    $display("FAIL %s busy/complete at T+%0d: got %b%b want 10", tag, c,
                             dif.busy, dif.complete);
                end
            end else begin
                checks++;
                if ({dif.busy, dif.complete, dif.raise_div_zero} !== {2'b01, ee}) begin
                    errors++;
                    $display("FAIL %s status at T+%0d: busy/complete/err got %b%b%b want 01%b",
                             tag, c, dif.busy, dif.complete, dif.raise_div_zero, ee);
                end
                checks++;
                if (dif.quotient !== eq || dif.remainder !== er) begin
                    errors++;
                    $display("FAIL %s result (%h/%h is8=%0d sgn=%0d): got q=%h r=%h want q=%h r=%h",
                             tag, dvd, dvs, is8, sgn, dif.quotient, dif.remainder, eq, er);
                end
            end
        end
        dif.start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        dif.start = 1'b0; dif.dividend = '0; dif.divisor = '0;
        dif.is_8_bit = 1'b0; dif.is_signed = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({dif.quotient, dif.remainder, dif.busy, dif.complete, dif.raise_div_zero} !== 35'd0) begin
            errors++;
            $display("FAIL reset_outputs: got q=%h r=%h b=%b c=%b e=%b want all 0",
                     dif.quotient, dif.remainder, dif.busy, dif.complete, dif.raise_div_zero);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (dif.busy !== 1'b0 || dif.complete !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b complete=%b want 0 0", dif.busy, dif.complete);
        end
    endtask

    task automatic test_directed();
        run_div(32'h0001_0000, 16'h0003, 0, 0, 0, "udiv16");
        checks++;
        if (dif.quotient !== 16'h5555 || dif.remainder !== 16'h0001) begin
            errors++;
            $display("FAIL udiv16_const: got q=%h r=%h want q=5555 r=0001",
                     dif.quotient, dif.remainder);
        end
        @(negedge clk);
        run_div(32'h0000_FF9C, 16'h0007, 1, 1, 0, "idiv8");
        checks++;
        if (dif.quotient !== 16'h00F2 || dif.remainder !== 16'h00FE) begin
            errors++;
            $display("FAIL idiv8_const: got q=%h r=%h want q=00f2 r=00fe",
                     dif.quotient, dif.remainder);
        end
        @(negedge clk);
        run_div(32'hFFF0_0005, 16'h0013, 0, 1, 0, "idiv16_neg");
        @(negedge clk);
        run_div(32'h0000_00FF, 16'h0010, 1, 0, 0, "udiv8");
        @(negedge clk);
    endtask

    task automatic test_div_zero();
        run_div(32'h1234_5678, 16'h0000, 0, 0, 0, "divzero16");
        @(negedge clk);
        run_div(32'h0000_0042, 16'hFF00, 1, 1, 0, "divzero8");
        @(negedge clk);
    endtask

    task automatic test_overflow();
        run_div(32'h0002_0000, 16'h0001, 0, 0, 0, "ovf_udiv16");
        @(negedge clk);
        run_div(32'hFFFF_8000, 16'hFFFF, 0, 1, 0, "ovf_idiv16");
        @(negedge clk);
        run_div(32'h0000_FF80, 16'h00FF, 1, 1, 0, "ovf_idiv8");
        @(negedge clk);
        run_div(32'h0000_0080, 16'h0001, 1, 1, 0, "ovf_idiv8_pos");
        @(negedge clk);
        run_div(32'h0000_FF81, 16'h00FF, 1, 1, 0, "max_idiv8");
        @(negedge clk);
    endtask

    task automatic test_ignore_start();
        int seen;
        run_div(32'h0001_0000, 16'h0003, 0, 0, 5, "ignore_start");
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (dif.complete === 1'b1 || dif.busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL ignore_start_queued: got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        run_div(32'h0000_7531, 16'h00C8, 0, 0, 0, "b2b_first");
        run_div(32'hFFFF_0F00, 16'h0123, 0, 1, 0, "b2b_second");
        run_div(32'h0000_1234, 16'h0056, 1, 0, 0, "b2b_third");
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int seen;
        run_div(32'h0001_0000, 16'h0003, 0, 0, 0, "pre_reset");
        @(negedge clk);
        dif.start = 1'b1; dif.dividend = 32'h0004_0000; dif.divisor = 16'h0007;
        dif.is_8_bit = 1'b0; dif.is_signed = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            dif.start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({dif.quotient, dif.remainder, dif.busy, dif.complete, dif.raise_div_zero} !== 35'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got q=%h r=%h b=%b c=%b e=%b want all 0",
                     dif.quotient, dif.remainder, dif.busy, dif.complete, dif.raise_div_zero);
        end
        @(negedge clk);
        reset_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (dif.complete === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_mid_complete: got %0d pulses want 0", seen);
        end
        run_div(32'h0000_FF9C, 16'h0007, 1, 1, 0, "post_reset");
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [15:0] v;
        bit is8, sgn;
        for (int i = 0; i < 150; i++) begin
            is8 = bit'($urandom_range(0, 1));
            sgn = bit'($urandom_range(0, 1));
            d = $urandom;
            d = d >> $urandom_range(0, 31);
            if (sgn && $urandom_range(0, 1) == 1) d = ~d + 32'd1;
            v = 16'($urandom);
            v = v >> $urandom_range(0, 15);
            if (sgn && $urandom_range(0, 1) == 1) v = ~v + 16'd1;
            if ($urandom_range(0, 19) == 0) v = 16'h0000;
            run_div(d, v, is8, sgn, 0, "random");
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_div_zero();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
